// File: rtl/fc_bias_requant.sv
`default_nettype none
// ============================================================================
// Module   : fc_bias_requant
// Brief    : FC-layer output stage. Per neuron: fetch int32 bias from the
//            bias ROM, add it to the MAC accumulator with saturation,
//            requantize (Q0.31 multiply, rounding shift, zero point) and emit
//            one saturated int8 activation over a valid/ready handshake.
// Config   : define FC_RELU_EN to fuse ReLU into the FC1 clamp (lower bound
//            becomes out_zp for layer FC1; FC2 keeps -128).
// Revision : 1.0 - initial release
// ============================================================================
module fc_bias_requant #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 74,
    parameter int FC1_SIZE  = 64,
    parameter int FC2_SIZE  = 10,
    parameter int OUT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          fc_layer_select,
    input  logic signed [31:0]            quant_mult,
    input  logic        [4:0]             quant_shift,
    input  logic signed [OUT_WIDTH-1:0]   out_zp,
    input  logic signed [WIDTH-1:0]       acc_in,
    input  logic                          acc_valid,
    output logic                          acc_ready,
    output logic                          bias_read_enable,
    output logic                          bias_fc_select,
    output logic [$clog2(DEPTH)-1:0]      bias_addr,
    input  logic signed [WIDTH-1:0]       bias_in,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [$clog2(FC1_SIZE)-1:0]   out_idx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(FC1_SIZE);
    localparam int PW = WIDTH + 32;

    localparam logic signed [WIDTH-1:0] c_SUM_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_SUM_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [31:0]      c_MULT_MIN  = 32'h8000_0000;
    localparam logic signed [PW-1:0]    c_PZERO     = '0;
    localparam logic signed [PW-1:0]    c_PONE      = PW'(64'sd1);
    localparam logic signed [PW-1:0]    c_NUDGE_POS = PW'(64'sd1073741824);
    localparam logic signed [PW-1:0]    c_NUDGE_NEG = PW'(-64'sd1073741823);
    localparam logic signed [PW-1:0]    c_TRUNC_ADJ = PW'(64'sd2147483647);
    localparam logic signed [PW-1:0]    c_H_MAX     = PW'(c_SUM_MAX);
    localparam logic signed [PW-1:0]    c_Y_MAX     = PW'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0]    c_Y_MIN     = ~c_Y_MAX;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAITB = 3'd2,
        S_ACC   = 3'd3,
        S_MUL   = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                        state_q, state_d;
    logic                          layer_q, layer_d;
    logic        [IW-1:0]          n_q, n_d;
    logic signed [WIDTH-1:0]       bias_q, bias_d;
    logic signed [WIDTH-1:0]       sum_q, sum_d;
    logic signed [OUT_WIDTH-1:0]   y_q, y_d;

    logic signed [WIDTH:0]         w_sum_wide;
    logic signed [WIDTH-1:0]       w_sum_sat;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_nudged;
    logic signed [PW-1:0]          w_h;
    logic signed [PW-1:0]          w_round;
    logic signed [PW-1:0]          w_r;
    logic signed [PW-1:0]          w_t;
    logic signed [PW-1:0]          w_lo;
    logic signed [OUT_WIDTH-1:0]   w_y;
    logic        [IW-1:0]          w_last_idx;

    assign w_last_idx = layer_q ? IW'(FC2_SIZE - 1) : IW'(FC1_SIZE - 1);

    // Bias add with one guard bit, clamped back to WIDTH on overflow
    always_comb begin
        w_sum_wide = {acc_in[WIDTH-1], acc_in} + {bias_q[WIDTH-1], bias_q};
        if (w_sum_wide[WIDTH] != w_sum_wide[WIDTH-1]) begin
            w_sum_sat = w_sum_wide[WIDTH] ? c_SUM_MIN : c_SUM_MAX;
        end else begin
            w_sum_sat = w_sum_wide[WIDTH-1:0];
        end
    end

    // Requantize the registered sum: rounding-doubling high multiply, rounding shift, zero point, clamp
    always_comb begin
        w_prod   = $signed({{32{sum_q[WIDTH-1]}}, sum_q}) *
                   $signed({{WIDTH{quant_mult[31]}}, quant_mult});
        w_nudged = w_prod + (w_prod[PW-1] ? c_NUDGE_NEG : c_NUDGE_POS);
        // Divide by 2^31 truncating toward zero: bias negatives up before the arithmetic shift
        w_h      = (w_nudged + (w_nudged[PW-1] ? c_TRUNC_ADJ : c_PZERO)) >>> 31;
        // The only product whose high half does not fit: min * min
        if ((sum_q == c_SUM_MIN) && (quant_mult == c_MULT_MIN)) begin
            w_h = c_H_MAX;
        end
        w_round  = (quant_shift == 5'd0) ? c_PZERO : (c_PONE <<< (quant_shift - 5'd1));
        w_r      = (w_h + w_round) >>> quant_shift;
        w_t      = w_r + PW'(out_zp);
`ifdef FC_RELU_EN
        w_lo     = layer_q ? c_Y_MIN : PW'(out_zp);
`else
        w_lo     = c_Y_MIN;
`endif
        if (w_t > c_Y_MAX) begin
            w_y = c_Y_MAX[OUT_WIDTH-1:0];
        end else if (w_t < w_lo) begin
            w_y = w_lo[OUT_WIDTH-1:0];
        end else begin
            w_y = w_t[OUT_WIDTH-1:0];
        end
    end

    // Next-state and datapath register updates for the per-neuron sequence
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        n_d     = n_q;
        bias_d  = bias_q;
        sum_d   = sum_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    layer_d = fc_layer_select;
                    n_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAITB;
            end
            S_WAITB: begin
                bias_d  = bias_in;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (acc_valid) begin
                    sum_d   = w_sum_sat;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                y_d     = w_y;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (n_q == w_last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any layer in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= 1'b0;
            n_q     <= '0;
            bias_q  <= '0;
            sum_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            n_q     <= n_d;
            bias_q  <= bias_d;
            sum_q   <= sum_d;
            y_q     <= y_d;
        end
    end

    assign acc_ready        = (state_q == S_ACC);
    assign bias_read_enable = (state_q == S_FETCH);
    assign bias_fc_select   = layer_q;
    assign bias_addr        = AW'(n_q);
    assign out_data         = y_q;
    assign out_idx          = n_q;
    assign out_valid        = (state_q == S_OUT);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fc_bias_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_bias_requant
// Brief    : Directed self-checking bench for fc_bias_requant with a bias ROM
//            model and an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_bias_requant;

    localparam int     WIDTH     = 32;
    localparam int     DEPTH     = 74;
    localparam int     FC1_SIZE  = 64;
    localparam int     FC2_SIZE  = 10;
    localparam int     OUT_WIDTH = 8;
    localparam longint INT_MAX   = 64'sd2147483647;
    localparam longint INT_MIN   = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 fc_layer_select;
    logic [31:0]          quant_mult;
    logic [4:0]           quant_shift;
    logic [7:0]           out_zp;
    logic [31:0]          acc_in;
    logic                 acc_valid;
    logic                 acc_ready;
    logic                 bias_read_enable;
    logic                 bias_fc_select;
    logic [6:0]           bias_addr;
    logic [31:0]          bias_in = '0;
    logic [7:0]           out_data;
    logic [5:0]           out_idx;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    typedef struct packed {
        logic [7:0] data;
        logic [5:0] idx;
    } exp_t;

    exp_t               sb[$];
    int                 checks = 0;
    int                 errors = 0;
    logic signed [31:0] rom [DEPTH];
    bit                 cur_layer;
    longint             cur_mult;
    int                 cur_shift;
    longint             cur_zp;

    fc_bias_requant #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .FC1_SIZE (FC1_SIZE),
        .FC2_SIZE (FC2_SIZE),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .fc_layer_select (fc_layer_select),
        .quant_mult      (quant_mult),
        .quant_shift     (quant_shift),
        .out_zp          (out_zp),
        .acc_in          (acc_in),
        .acc_valid       (acc_valid),
        .acc_ready       (acc_ready),
        .bias_read_enable(bias_read_enable),
        .bias_fc_select  (bias_fc_select),
        .bias_addr       (bias_addr),
        .bias_in         (bias_in),
        .out_data        (out_data),
        .out_idx         (out_idx),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Synchronous bias ROM: one cycle read latency, FC2 entries after FC1
    always @(posedge clk) begin
        if (bias_read_enable) begin
            bias_in <= rom[bias_fc_select ? FC1_SIZE + int'(bias_addr) : int'(bias_addr)];
        end
    end

    function automatic logic [7:0] model(input longint acc, input longint bias, input longint mult,
                                         input int sh, input longint zp, input bit layer);
        longint sum, p, nud, h, r, y, lo;
        sum = acc + bias;
        if (sum > INT_MAX) sum = INT_MAX;
        if (sum < INT_MIN) sum = INT_MIN;
        if (sum == INT_MIN && mult == INT_MIN) begin
            h = INT_MAX;
        end else begin
            p   = sum * mult;
            nud = (p >= 0) ? 64'sd1073741824 : -64'sd1073741823;
            h   = (p + nud) / 64'sd2147483648;
        end
        r  = (sh > 0) ? ((h + (64'sd1 <<< (sh - 1))) >>> sh) : h;
        y  = r + zp;
        lo = -128;
`ifdef FC_RELU_EN
        if (!layer) lo = zp;
`endif
        if (y > 127) y = 127;
        if (y < lo)  y = lo;
        return y[7:0];
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acc_ready"}, acc_ready, 0);
        chk({tag, "_bias_read_enable"}, bias_read_enable, 0);
        chk({tag, "_bias_fc_select"}, bias_fc_select, 0);
        chk({tag, "_bias_addr"}, bias_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_sb_size"}, sb.size(), 1);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_done_low"}, done, 0);
        if (sb.size() > 0) begin
            chk({tag, "_out_data"}, out_data, sb[0].data);
            chk({tag, "_out_idx"}, out_idx, sb[0].idx);
        end
    endtask

    // Called just after a rising edge while the DUT is in IDLE
    task automatic start_layer(input bit layer, input longint mult, input int sh, input longint zp);
        cur_layer       = layer;
        cur_mult        = mult;
        cur_shift       = sh;
        cur_zp          = zp;
        quant_mult      = mult[31:0];
        quant_shift     = sh[4:0];
        out_zp          = zp[7:0];
        fc_layer_select = layer;
        start           = 1'b1;
        @(posedge clk); #1;
        start           = 1'b0;
    endtask

    // Present the accumulator until accepted, recording the fetch it follows
    task automatic feed_acc(input int idx, input longint acc);
        bit     fetched;
        exp_t   e;
        longint bias;
        acc_in    = acc[31:0];
        acc_valid = 1'b1;
        fetched   = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bias_read_enable) begin
                fetched = 1'b1;
                chk("bias_addr", bias_addr, idx);
                chk("bias_fc_select", bias_fc_select, cur_layer);
            end
            if (acc_ready) break;
        end
        chk("acc_ready_reached", acc_ready, 1);
        chk("fetch_seen", fetched, 1);
        bias   = rom[cur_layer ? FC1_SIZE + idx : idx];
        e.data = model(acc, bias, cur_mult, cur_shift, cur_zp, cur_layer);
        e.idx  = idx[5:0];
        sb.push_back(e);
        @(posedge clk); #1;
        acc_valid = 1'b0;
        acc_in    = $urandom;
    endtask

    // One full neuron: acc handshake, latency check, stall, accept
    task automatic do_neuron(input int idx, input longint acc, input int stall, input bit poke);
        int   lat;
        exp_t e;
        feed_acc(idx, acc);
        if (poke) begin
            start           = 1'b1;
            fc_layer_select = ~cur_layer;
        end
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        start           = 1'b0;
        fc_layer_select = cur_layer;
        chk("acc_to_out_latency", lat, 2);
        repeat (stall) begin
            check_out("stall");
            @(negedge clk);
        end
        check_out("present");
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_out("accept");
        if (sb.size() > 0) e = sb.pop_front();
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic finish_layer();
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("idle_after_done", busy, 0);
        @(posedge clk); #1;
    endtask

    longint accs   [4][10];
    longint mults  [4];
    int     shifts [4];
    longint zps    [4];
    int     stalls [4];

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        fc_layer_select = 1'b0;
        quant_mult      = '0;
        quant_shift     = '0;
        out_zp          = '0;
        acc_in          = '0;
        acc_valid       = 1'b0;
        out_ready       = 1'b0;

        for (int i = 0; i < FC1_SIZE; i++) rom[i] = 32'(i * 37 - 900);
        rom[0]  = 0;
        rom[64] = 24;    rom[65] = 5;     rom[66] = 0;     rom[67] = 0;
        rom[68] = -7;    rom[69] = 100;   rom[70] = -100;  rom[71] = 2000;
        rom[72] = -2000; rom[73] = 1;

        accs[0] = '{1000, INT_MAX, -300, 5000, -5000, 123456, -2000000, 7, -1, 640};
        accs[1] = '{50, INT_MAX, -300, 90, -60, 10, -10, 0, 300, -130};
        accs[2] = '{-100, 20, INT_MIN, 50, -120, 1, -1, 127, 128, -129};
        accs[3] = '{-24, 0, 6, -6, 7, 3, -3, 10, 1, 0};
        mults   = '{64'sd1073741824, INT_MAX, INT_MIN, 64'sd1073741824};
        shifts  = '{3, 0, 0, 1};
        zps     = '{0, -3, 0, 0};
        stalls  = '{3, 1, 0, 0};

        // Reset state, both while asserted and after release
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");
        @(posedge clk); #1;

        // Four complete FC2 runs with different requantization settings
        for (int r = 0; r < 4; r++) begin
            start_layer(1'b1, mults[r], shifts[r], zps[r]);
            for (int n = 0; n < FC2_SIZE; n++) begin
                do_neuron(n, accs[r][n], stalls[r], (r == 1) && (n == 3));
            end
            finish_layer();
        end

        // FC1 run aborted by reset in the middle of neuron 5
        start_layer(1'b0, 64'sd1073741824, 0, 0);
        do_neuron(0, -300, 0, 1'b0);
        do_neuron(1, 400, 0, 1'b1);
        do_neuron(2, -50, 2, 1'b0);
        do_neuron(3, 1000, 0, 1'b0);
        do_neuron(4, 77, 0, 1'b0);
        feed_acc(5, 12345);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Restart begins again at neuron 0
        start_layer(1'b0, 64'sd1073741824, 2, 5);
        do_neuron(0, 25, 1, 1'b0);
        do_neuron(1, -4000, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
